// File: rtl/cache_pkg.sv
// Shared types and constants for the cache controller: FSM state type, widths and the
// byte-address field layout (word offset, index, tag).
package cache_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned C_WIDTH   = 13;
    localparam int unsigned OFFSET_W  = 2;
    localparam int unsigned INDEX_LSB = OFFSET_W;
    localparam int unsigned INDEX_MSB = C_WIDTH - 1;
    localparam int unsigned TAG_LSB   = C_WIDTH;
    localparam int unsigned TAG_MSB   = XLEN - 1;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        ALLOCATE,
        FILL
    } cache_state_e;

endpackage

// File: rtl/cache_controller_if.sv
// Bundles the CPU, cache-array and memory signals of the cache controller.
// master = controller side, slave = CPU/cache/memory side.
interface cache_controller_if #(
    parameter int unsigned XLEN = 32
);

    logic            cpu_req;
    logic            cpu_we;
    logic [XLEN-1:0] cpu_addr;
    logic [XLEN-1:0] cpu_wdata;
    logic [XLEN-1:0] cpu_rdata;
    logic            cpu_ready;

    logic [XLEN-1:0] cache_addr;
    logic            cache_we;
    logic [XLEN-1:0] cache_din;
    logic [XLEN-1:0] cache_dout;
    logic            cache_hit;
    logic            cache_dirty;
    logic [XLEN-1:0] cache_miss_addr;

    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ack;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready,
        output cache_addr, cache_we, cache_din,
        input  cache_dout, cache_hit, cache_dirty, cache_miss_addr,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready,
        input  cache_addr, cache_we, cache_din,
        output cache_dout, cache_hit, cache_dirty, cache_miss_addr,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/cache_controller.sv
// Write-back, write-allocate cache controller FSM (IDLE/COMPARE/WRITEBACK/ALLOCATE/FILL).
// Optional hit/miss statistics outputs are built when CACHE_CTRL_STATS_EN is defined.
module cache_controller
    import cache_pkg::*;
#(
    parameter int unsigned XLEN    = cache_pkg::XLEN,
    parameter int unsigned C_WIDTH = cache_pkg::C_WIDTH,
    parameter int unsigned STATS_W = 32
) (
    input  logic               clk,
    input  logic               rst_b,
`ifdef CACHE_CTRL_STATS_EN
    output logic [STATS_W-1:0] hit_count,
    output logic [STATS_W-1:0] miss_count,
`endif
    cache_controller_if.master bus
);

    if (C_WIDTH <= OFFSET_W || C_WIDTH >= XLEN) begin : g_bad_c_width
        $error("cache_controller: C_WIDTH out of range");
    end
    if (STATS_W == 0) begin : g_bad_stats_w
        $error("cache_controller: STATS_W must be non-zero");
    end

    cache_state_e    r_state;
    cache_state_e    w_state_next;
    logic            r_we;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_fill;
    logic            w_accept;
    logic            w_fill_capture;

    assign w_accept       = (r_state == IDLE) && bus.cpu_req;
    assign w_fill_capture = (r_state == ALLOCATE) && bus.mem_ack;

    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_fill  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_we    <= bus.cpu_we;
                r_addr  <= bus.cpu_addr;
                r_wdata <= bus.cpu_wdata;
            end
            if (w_fill_capture) begin
                r_fill <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        bus.cpu_rdata  = '0;
        bus.cpu_ready  = 1'b0;
        bus.cache_addr = '0;
        bus.cache_we   = 1'b0;
        bus.cache_din  = '0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;

        case (r_state)
            IDLE: begin
                if (bus.cpu_req) begin
                    w_state_next = COMPARE;
                end
            end
            COMPARE: begin
                bus.cache_addr = r_addr;
                if (bus.cache_hit) begin
                    bus.cpu_ready = 1'b1;
                    if (r_we) begin
                        bus.cache_we  = 1'b1;
                        bus.cache_din = r_wdata;
                    end else begin
                        bus.cpu_rdata = bus.cache_dout;
                    end
                    w_state_next = IDLE;
                end else begin
                    w_state_next = bus.cache_dirty ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                // cache_dout still reads the victim line because the index is unchanged
                bus.cache_addr = r_addr;
                bus.mem_req    = 1'b1;
                bus.mem_we     = 1'b1;
                bus.mem_addr   = bus.cache_miss_addr;
                bus.mem_wdata  = bus.cache_dout;
                if (bus.mem_ack) begin
                    w_state_next = ALLOCATE;
                end
            end
            ALLOCATE: begin
                bus.cache_addr = r_addr;
                bus.mem_req    = 1'b1;
                bus.mem_addr   = {r_addr[XLEN-1:OFFSET_W], OFFSET_W'(0)};
                if (bus.mem_ack) begin
                    w_state_next = FILL;
                end
            end
            FILL: begin
                // A line is one word, so a store's data covers the whole fill word
                bus.cache_addr = r_addr;
                bus.cache_we   = 1'b1;
                bus.cache_din  = r_we ? r_wdata : r_fill;
                w_state_next   = COMPARE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

`ifdef CACHE_CTRL_STATS_EN
    logic               r_retry;
    logic [STATS_W-1:0] r_hit_count;
    logic [STATS_W-1:0] r_miss_count;
    logic               w_first_hit;
    logic               w_miss;

    assign w_first_hit = (r_state == COMPARE) && bus.cache_hit && !r_retry;
    assign w_miss      = (r_state == COMPARE) && !bus.cache_hit;

    // r_retry marks the COMPARE that follows FILL so it is not counted as a hit
    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_retry      <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_accept) begin
                r_retry <= 1'b0;
            end else if (r_state == FILL) begin
                r_retry <= 1'b1;
            end
            if (w_first_hit) begin
                r_hit_count <= r_hit_count + STATS_W'(1);
            end
            if (w_miss) begin
                r_miss_count <= r_miss_count + STATS_W'(1);
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: behavioural cache array and memory, directed
// CPU accesses with expected responses queued and checked by separate monitor processes.
module tb_cache_controller;
    import cache_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] data;
        int          lat;
    } cpu_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_exp_t;

    logic clk = 1'b0;
    logic rst_b;
    logic cache_clr;

    always #5 clk = ~clk;

    cache_controller_if #(.XLEN(32)) bus ();

`ifdef CACHE_CTRL_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    cache_controller #(
        .XLEN   (32),
        .C_WIDTH(13),
        .STATS_W(32)
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
`ifdef CACHE_CTRL_STATS_EN
        .hit_count (hit_count),
        .miss_count(miss_count),
`endif
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int req_cyc = 0;
    int mem_delay = 0;

    cpu_exp_t cpu_q[$];
    mem_exp_t mem_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Direct-mapped cache array model: one word per line, index = addr[12:2]
    logic [31:0] c_data  [2048];
    logic [18:0] c_tag   [2048];
    logic        c_valid [2048];
    logic        c_dirty [2048];
    logic [10:0] c_idx;

    assign c_idx = bus.cache_addr[INDEX_MSB:INDEX_LSB];

    always_comb begin
        bus.cache_dout      = c_data[c_idx];
        bus.cache_hit       = c_valid[c_idx] && (c_tag[c_idx] == bus.cache_addr[TAG_MSB:TAG_LSB]);
        bus.cache_dirty     = c_valid[c_idx] && c_dirty[c_idx];
        bus.cache_miss_addr = {c_tag[c_idx], c_idx, 2'b00};
    end

    always @(posedge clk) begin
        if (cache_clr) begin
            for (int i = 0; i < 2048; i++) begin
                c_valid[i] <= 1'b0;
                c_dirty[i] <= 1'b0;
                c_data[i]  <= '0;
                c_tag[i]   <= '0;
            end
        end else if (bus.cache_we) begin
            c_data[c_idx]  <= bus.cache_din;
            c_tag[c_idx]   <= bus.cache_addr[TAG_MSB:TAG_LSB];
            c_valid[c_idx] <= 1'b1;
            // the CPU holds cpu_we for the whole access, so it tells store from load fill
            c_dirty[c_idx] <= bus.cpu_we;
        end
    end

    // Memory responder: checks each new request against the queue, acks after mem_delay
    initial begin
        logic [31:0] mem_m [logic [31:0]];
        mem_exp_t    m;
        logic        we_l;
        logic [31:0] addr_l;
        logic [31:0] wd_l;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        mem_m[32'h0000_0010] = 32'hDEAD_BEEF;
        mem_m[32'h0000_2010] = 32'h0BAD_F00D;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (bus.mem_req === 1'b1) begin
                if (mem_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_mem_req: got we=%0b addr=0x%08h, expected none",
                             bus.mem_we, bus.mem_addr);
                end else begin
                    m = mem_q.pop_front();
                    check("mem_we", 32'(bus.mem_we), 32'(m.we));
                    check("mem_addr", bus.mem_addr, m.addr);
                    if (m.we) check("mem_wdata", bus.mem_wdata, m.wdata);
                end
                we_l   = bus.mem_we;
                addr_l = bus.mem_addr;
                wd_l   = bus.mem_wdata;
                for (int i = 0; i < mem_delay; i++) @(negedge clk);
                if (we_l) begin
                    mem_m[addr_l] = wd_l;
                end else begin
                    bus.mem_rdata = mem_m.exists(addr_l) ? mem_m[addr_l] : 32'h0;
                end
                bus.mem_ack = 1'b1;
            end
        end
    end

    // CPU-side monitor: compares every cpu_ready against the oldest queued expectation
    initial begin
        cpu_exp_t e;
        forever begin
            @(negedge clk);
            if (rst_b === 1'b0 && bus.cpu_ready === 1'b1) begin
                if (cpu_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: got cpu_ready=1, expected 0");
                end else begin
                    e = cpu_q.pop_front();
                    if (e.we) begin
                        check("store_cache_we", 32'(bus.cache_we), 32'd1);
                        check("store_cache_din", bus.cache_din, e.data);
                    end else begin
                        check("load_rdata", bus.cpu_rdata, e.data);
                        check("load_cache_we", 32'(bus.cache_we), 32'd0);
                    end
                    check("ready_latency", 32'(cyc + 1 - req_cyc), 32'(e.lat));
                end
            end
        end
    end

    task automatic push_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        mem_exp_t m;
        m.we    = we;
        m.addr  = addr;
        m.wdata = wdata;
        mem_q.push_back(m);
    endtask

    task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_data, input int lat);
        cpu_exp_t e;
        bit       done;
        e.we   = we;
        e.data = exp_data;
        e.lat  = lat;
        cpu_q.push_back(e);
        @(negedge clk);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        req_cyc       = cyc;
        done          = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (bus.cpu_ready === 1'b1) done = 1'b1;
        end
        bus.cpu_req = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got no cpu_ready in 40 cycles, expected one (addr 0x%08h)",
                     addr);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cpu_ready"}, 32'(bus.cpu_ready), 32'd0);
        check({tag, "_cache_we"}, 32'(bus.cache_we), 32'd0);
        check({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
        check({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        check({tag, "_cache_addr"}, bus.cache_addr, 32'd0);
        check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    endtask

    initial begin
        int  bad_req;
        int  bad_ready;
        bit  saw_ack;
        bit  in_wb;
        rst_b         = 1'b1;
        cache_clr     = 1'b1;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_b     = 1'b0;
        cache_clr = 1'b0;

        // cold clean miss, then hit, then store hit
        push_mem(1'b0, 32'h0000_0010, 32'h0);
        cpu_access(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 5);
        cpu_access(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 2);
        cpu_access(1'b1, 32'h0000_0010, 32'h1234_5678, 32'h1234_5678, 2);

        // same index, different tag: dirty victim written back first
        push_mem(1'b1, 32'h0000_0010, 32'h1234_5678);
        push_mem(1'b0, 32'h0000_2010, 32'h0);
        cpu_access(1'b0, 32'h0000_2010, 32'h0, 32'h0BAD_F00D, 6);
`ifdef CACHE_CTRL_STATS_EN
        @(negedge clk);
        check("hit_count", hit_count, 32'd2);
        check("miss_count", miss_count, 32'd2);
`endif

        // reloading 0x10 returns the written-back store data from memory
        push_mem(1'b0, 32'h0000_0010, 32'h0);
        cpu_access(1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 5);
        cpu_access(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 32'hCAFE_F00D, 2);

        // reset during WRITEBACK with a delayed ack
        mem_delay = 4;
        push_mem(1'b1, 32'h0000_0010, 32'hCAFE_F00D);
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 32'h0000_2010;
        in_wb        = 1'b0;
        for (int i = 0; i < 20 && !in_wb; i++) begin
            @(negedge clk);
            if (bus.mem_req === 1'b1 && bus.mem_we === 1'b1) in_wb = 1'b1;
        end
        check("reached_writeback", 32'(in_wb), 32'd1);
        rst_b       = 1'b1;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        check_idle_outputs("midreset");
        rst_b     = 1'b0;
        bad_req   = 0;
        bad_ready = 0;
        saw_ack   = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.mem_ack === 1'b1) saw_ack = 1'b1;
            if (bus.mem_req !== 1'b0) bad_req++;
            if (bus.cpu_ready !== 1'b0) bad_ready++;
        end
        check("late_ack_seen", 32'(saw_ack), 32'd1);
        check("late_ack_mem_req", 32'(bad_req), 32'd0);
        check("late_ack_cpu_ready", 32'(bad_ready), 32'd0);
        mem_delay = 0;

        // cache array survives the controller reset: line 0x10 still resident
        cpu_access(1'b0, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 2);
`ifdef CACHE_CTRL_STATS_EN
        @(negedge clk);
        check("hit_count_after_reset", hit_count, 32'd1);
        check("miss_count_after_reset", miss_count, 32'd0);
`endif

        repeat (3) @(negedge clk);
        check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
        check("mem_q_drained", 32'(mem_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
